// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared definitions for the register-file dump engine.
// Holds the FSM state encoding and the register-file geometry defaults,
// which the register file itself also reuses.
package reg_dump_pkg;

   localparam int DEF_NREGS = 32;
   localparam int DEF_AW    = $clog2(DEF_NREGS);
   localparam int DEF_DW    = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/reg_dump.sv
// reg_dump: sequential read-out engine for the CPU register file.
// On start it walks register numbers first..last (wrapping through NREGS-1
// to 0) on a dedicated combinational read port. Each value is captured in
// its READ cycle and sent out as one valid/ready beat tagged with its
// register number.
// Optional feature: define REG_DUMP_CHKSUM_EN to append one checksum beat
// (XOR of all transmitted words, idx 0, last 1) after the register beats.
module reg_dump
   import reg_dump_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] first,
   input  logic [AW-1:0] last,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rd_num,
   input  logic [DW-1:0] rd_data,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic [DW-1:0] dout_data,
   output logic [AW-1:0] dout_idx,
   output logic          dout_last
);

   localparam logic [AW-1:0] TOP_NUM = AW'(NREGS - 1);

   state_t        state;
   logic [AW-1:0] end_num;   // last register of the dump, latched with start
`ifdef REG_DUMP_CHKSUM_EN
   logic [DW-1:0] chk;       // XOR of words already handed downstream
   logic          final_reg; // the beat on the bus is the last register beat
`endif

   // Dump FSM; rd_num doubles as the index counter so it holds outside READ.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the output data registers are reset as well, because their
         // values are visible on the ports right after reset.
         state      <= IDLE;
         end_num    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_num     <= '0;
         dout_valid <= 1'b0;
         dout_data  <= '0;
         dout_idx   <= '0;
         dout_last  <= 1'b0;
`ifdef REG_DUMP_CHKSUM_EN
         chk        <= '0;
         final_reg  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every register
         // updates from the values present before the edge.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rd_num  <= first;
                  end_num <= last;
                  busy    <= 1'b1;
                  state   <= READ;
`ifdef REG_DUMP_CHKSUM_EN
                  chk     <= '0;
`endif
               end
            end

            READ: begin
               dout_data  <= rd_data;
               dout_idx   <= rd_num;
               dout_valid <= 1'b1;
`ifdef REG_DUMP_CHKSUM_EN
               final_reg  <= (rd_num == end_num);
               dout_last  <= 1'b0;
`else
               dout_last  <= (rd_num == end_num);
`endif
               state      <= SEND;
            end

            SEND: begin
               if (dout_ready) begin
`ifdef REG_DUMP_CHKSUM_EN
                  chk <= chk ^ dout_data;
                  if (final_reg) begin
                     // Last register accepted: replace it with the checksum beat.
                     final_reg <= 1'b0;
                     dout_data <= chk ^ dout_data;
                     dout_idx  <= '0;
                     dout_last <= 1'b1;
                  end else
`endif
                  if (dout_last) begin
                     dout_valid <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     state      <= DONE;
                  end else begin
                     dout_valid <= 1'b0;
                     rd_num     <= (rd_num == TOP_NUM) ? '0 : rd_num + 1'b1;
                     state      <= READ;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: self-checking bench for reg_dump. A queue-based model plans
// the expected beats of each dump from first/last and the register-file
// contents; a negedge compare process checks busy, done and every valid
// beat against it. Directed scenarios pin the model with literal values.
// Build with REG_DUMP_CHKSUM_EN defined to cover the checksum beat.
module tb_reg_dump;
   import reg_dump_pkg::*;

   localparam int NREGS = DEF_NREGS;
   localparam int AW    = DEF_AW;
   localparam int DW    = DEF_DW;
`ifdef REG_DUMP_CHKSUM_EN
   localparam int CHK_BEATS = 1;
`else
   localparam int CHK_BEATS = 0;
`endif

   typedef struct {
      logic [AW-1:0] idx;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] first;
   logic [AW-1:0] last;
   logic          busy;
   logic          done;
   logic [AW-1:0] rd_num;
   logic [DW-1:0] rd_data;
   logic          dout_valid;
   logic          dout_ready;
   logic [DW-1:0] dout_data;
   logic [AW-1:0] dout_idx;
   logic          dout_last;

   logic [DW-1:0] regfile [NREGS];
   bit            ready_rand;
   bit            ready_hold;
   int            cyc;

   beat_t exp_q[$];
   beat_t log_q[$];
   bit    exp_busy;
   bit    exp_done;
   int    n_done;
   int    n_checks;
   int    n_bad;

   reg_dump dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .first      (first),
      .last       (last),
      .busy       (busy),
      .done       (done),
      .rd_num     (rd_num),
      .rd_data    (rd_data),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_data  (dout_data),
      .dout_idx   (dout_idx),
      .dout_last  (dout_last)
   );

   assign rd_data = regfile[rd_num];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, req, $time);
      end
   endtask

   function automatic int beat_count(input int f, input int l);
      return (((l - f) % NREGS) + NREGS) % NREGS + 1;
   endfunction

   // Expected beats of one dump, snapshotting the file at start time.
   function automatic void plan(input int f, input int l);
      int            n;
      logic [DW-1:0] x;
      beat_t         b;
      n = beat_count(f, l);
      x = '0;
      for (int k = 0; k < n; k++) begin
         b.idx  = AW'((f + k) % NREGS);
         b.data = regfile[(f + k) % NREGS];
         b.last = (CHK_BEATS == 0) && (k == n - 1);
         x      = x ^ b.data;
         exp_q.push_back(b);
      end
`ifdef REG_DUMP_CHKSUM_EN
      b.idx  = '0;
      b.data = x;
      b.last = 1'b1;
      exp_q.push_back(b);
`endif
   endfunction

   // Compare process: checks outputs mid-cycle, then advances the model
   // to what the coming edge must do with the current inputs.
   always @(negedge clk) begin
      bit    idle;
      bit    fin;
      beat_t b;
      if (!rst) begin
         check("reset_ctrl", {busy, done, dout_valid, dout_last}, '0);
         check("reset_nums", {rd_num, dout_idx}, '0);
         check("reset_data", dout_data, '0);
         exp_q.delete();
         exp_busy = 1'b0;
         exp_done = 1'b0;
      end else begin
         check("busy", busy, exp_busy);
         check("done", done, exp_done);
         if (done) n_done++;
         if (dout_valid) begin
            check("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               check("beat_idx", dout_idx, exp_q[0].idx);
               check("beat_data", dout_data, exp_q[0].data);
               check("beat_last", dout_last, exp_q[0].last);
            end
         end
         idle = !exp_busy && !exp_done;
         fin  = 1'b0;
         if (dout_valid && dout_ready) begin
            b.idx  = dout_idx;
            b.data = dout_data;
            b.last = dout_last;
            log_q.push_back(b);
            if (exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  exp_busy = 1'b0;
                  fin      = 1'b1;
               end
            end
         end
         if (idle && start) begin
            plan(int'(first), int'(last));
            exp_busy = 1'b1;
         end
         exp_done = fin;
      end
   end

   // Downstream ready: either random or a level set by the stimulus.
   initial begin
      dout_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         dout_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_hold;
      end
   end

   // One dump from start pulse to the cycle after done; lat is the cycle
   // index of done with the first cycle after the start edge counted as 1.
   task automatic do_dump(input int f, input int l, input bit noise, output int lat, output int lb);
      int t0;
      int nd0;
      lb  = log_q.size();
      nd0 = n_done;
      lat = -1;
      @(posedge clk); #1;
      first = AW'(f);
      last  = AW'(l);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t0    = cyc;
      for (int i = 0; i < 600; i++) begin
         if (done) begin
            lat = cyc - t0 + 1;
            break;
         end
         if (noise) begin
            start = ($urandom_range(0, 2) == 0);
            first = AW'($urandom);
            last  = AW'($urandom);
         end
         @(posedge clk); #1;
      end
      check("dump_done_seen", lat > 0, 1);
      start = noise;  // a start during DONE must be ignored
      @(posedge clk); #1;
      start = 1'b0;
      check("dump_one_done", n_done - nd0, 1);
   endtask

   initial begin
      int lat;
      int lb;
      int nb;
      int f;
      int l;
      int nd0;
      int nv;
      int wrap_idx [4] = '{30, 31, 0, 1};
      int wrap_data[4] = '{32'h11E, 32'h11F, 32'h000, 32'h101};

      rst = 1'b1;
      start = 1'b0;
      first = '0;
      last = '0;
      ready_rand = 1'b0;
      ready_hold = 1'b1;
      for (int i = 0; i < NREGS; i++) regfile[i] = (i == 0) ? '0 : DW'(32'h100 + i);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_rd_num", rd_num, 0);
      check("reset_dout_data", dout_data, 0);
      rst = 1'b1;

      // Basic 3-register dump, ready held high.
      do_dump(3, 5, 1'b0, lat, lb);
      nb = log_q.size() - lb;
      check("t1_beats", nb, 3 + CHK_BEATS);
      check("t1_latency", lat, 7 + CHK_BEATS);
      if (nb >= 3) begin
         for (int k = 0; k < 3; k++) begin
            check("t1_idx", log_q[lb + k].idx, 3 + k);
            check("t1_data", log_q[lb + k].data, 32'h103 + k);
            check("t1_last", log_q[lb + k].last, (k == 2) && (CHK_BEATS == 0));
         end
      end
`ifdef REG_DUMP_CHKSUM_EN
      if (nb == 4) begin
         check("t1_chk_data", log_q[lb + 3].data, 32'h102);
         check("t1_chk_idx", log_q[lb + 3].idx, 0);
         check("t1_chk_last", log_q[lb + 3].last, 1);
      end
`endif

      // Wrap-around range through register 0.
      do_dump(30, 1, 1'b0, lat, lb);
      nb = log_q.size() - lb;
      check("wrap_beats", nb, 4 + CHK_BEATS);
      check("wrap_latency", lat, 9 + CHK_BEATS);
      if (nb >= 4) begin
         for (int k = 0; k < 4; k++) begin
            check("wrap_idx", log_q[lb + k].idx, wrap_idx[k]);
            check("wrap_data", log_q[lb + k].data, wrap_data[k]);
         end
      end

      // Backpressure on a single-register dump.
      lb = log_q.size();
      ready_hold = 1'b0;
      @(posedge clk); #1;
      first = AW'(7);
      last  = AW'(7);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (dout_valid) break;
         @(posedge clk); #1;
      end
      check("bp_valid_seen", dout_valid, 1);
      for (int i = 0; i < 6; i++) begin
         check("bp_hold_valid", dout_valid, 1);
         check("bp_hold_data", dout_data, 32'h107);
         check("bp_hold_idx", dout_idx, 7);
         check("bp_hold_last", dout_last, CHK_BEATS == 0);
         if (i == 5) ready_hold = 1'b1;
         @(posedge clk); #1;
      end
`ifdef REG_DUMP_CHKSUM_EN
      check("bp_chk_data", dout_data, 32'h107);
      check("bp_chk_last", dout_last, 1);
      @(posedge clk); #1;
`endif
      check("bp_done", done, 1);
      @(posedge clk); #1;
      check("bp_beats", log_q.size() - lb, 1 + CHK_BEATS);

      // Start pulses while busy and during DONE are ignored.
      do_dump(3, 5, 1'b1, lat, lb);
      check("noise_beats", log_q.size() - lb, 3 + CHK_BEATS);

      // Reset in the second SEND of a 4-register dump, then restart.
      nd0 = n_done;
      @(posedge clk); #1;
      first = AW'(10);
      last  = AW'(13);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         if (dout_valid) nv++;
         if (nv == 2) break;
         @(posedge clk); #1;
      end
      check("rst_second_send", nv, 2);
      #2 rst = 1'b0;
      #1;
      check("rst_async_ctrl", {busy, done, dout_valid, dout_last}, '0);
      check("rst_async_data", dout_data, '0);
      check("rst_async_nums", {rd_num, dout_idx}, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_no_done", n_done - nd0, 0);
      do_dump(10, 13, 1'b0, lat, lb);
      nb = log_q.size() - lb;
      check("rst_restart_beats", nb, 4 + CHK_BEATS);
      check("rst_restart_latency", lat, 9 + CHK_BEATS);
      if (nb > 0) check("rst_restart_first", log_q[lb].idx, 10);

      // Full range: last = first-1 walks all registers.
      do_dump(5, 4, 1'b0, lat, lb);
      check("full_beats", log_q.size() - lb, NREGS + CHK_BEATS);
      check("full_latency", lat, 2 * NREGS + 1 + CHK_BEATS);

      // Random contents, ranges, backpressure and stray start pulses.
      ready_rand = 1'b1;
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < NREGS; i++) regfile[i] = $urandom;
         f = $urandom_range(0, NREGS - 1);
         l = $urandom_range(0, NREGS - 1);
         do_dump(f, l, 1'b1, lat, lb);
         check("rand_beats", log_q.size() - lb, beat_count(f, l) + CHK_BEATS);
      end
      ready_rand = 1'b0;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_dump.md
# reg_dump

Sequential read-out engine for the CPU register file: on a start pulse it walks a contiguous, wrap-around range of register numbers through a register-file read port. It captures each value and streams it out one word per valid/ready beat, tagged with its register number. It is the reader counterpart of the register-file write path. It sits beside the regs instance and feeds the debug display/serial path without disturbing the datapath ports.

## Interface
- NREGS, 32, number of architectural registers (power of two)
- AW, 5, register-number width, log2(NREGS)
- DW, 32, data word width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE
- first  in  AW  first register number, sampled with start
- last  in  AW  last register number, sampled with start
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after the final beat is accepted
- rd_num  out  AW  register number driven to a combinational register-file read port
- rd_data  in  DW  read data for rd_num, valid in the same cycle
- dout_valid  out  1  output word valid
- dout_ready  in  1  downstream accepts the word
- dout_data  out  DW  captured register value
- dout_idx  out  AW  register number of dout_data
- dout_last  out  1  marks the final beat of the dump

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: when start=1, latch first into the index counter and last into the end register, then go to READ. start is ignored in every other state.
- READ: rd_num=index. At the clock edge, capture rd_data into dout_data and index into dout_idx. Set dout_last=(index==last) and go to SEND.
- SEND: dout_valid=1. On dout_valid&dout_ready, if dout_last then go to DONE. Otherwise index=index+1 modulo NREGS and go to READ.
- DONE: done=1 for exactly one cycle, then IDLE.
- Range: beat count is ((last-first) mod NREGS)+1. last<first wraps through NREGS-1 to 0. first==last gives one beat.
- Register 0 is transmitted as whatever the file returns, normally 0. The block applies no special case.
- Values are snapshotted per register at its READ cycle. Writes to the file during a dump affect only registers not yet read.

## Timing
- Reset values: busy=0, done=0, rd_num=0, dout_valid=0, dout_data=0, dout_idx=0, dout_last=0, state=IDLE.
- Reset asserted mid-dump aborts immediately to the reset values. No done pulse is produced.
- start is sampled at edge T. busy=1 from T+1 until DONE is entered. READ occupies T+1. dout_valid first rises at T+2.
- With dout_ready held high, each beat costs 2 cycles (READ, SEND). An N-register dump asserts done at T+2N+1.
- While dout_valid=1 and dout_ready=0, dout_data, dout_idx and dout_last stay stable and dout_valid stays high.
- dout_ready high before dout_valid is allowed. A transfer occurs only in a cycle where both are high.
- busy=0 and done=1 in the DONE cycle. start in the DONE cycle is ignored. A new start is accepted from the following IDLE cycle.
- rd_num holds its last value outside READ.

## Configuration
- REG_DUMP_CHKSUM_EN defined: after the last register beat, one extra SEND beat is emitted with the following fields:
  - dout_data = XOR of all transmitted words
  - dout_idx = 0
  - dout_last = 1, and the register beat does not assert dout_last
  - done follows the checksum handshake, adding 1 cycle at full throughput
- REG_DUMP_CHKSUM_EN undefined: no accumulator and no extra beat. dout_last marks the final register beat.

## Structure
- Shared package/header: state encodings (IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3) and the NREGS/AW/DW defaults, reused by the register file.
- Single module with no sub-module. The index counter, FSM and output register are all in reg_dump.
- Top level: rd_num drives a dedicated read port of the register file, separate from the rs/rt ports.

## Test plan
- Registers i preloaded with 32'h100+i; first=3, last=5, ready held high → beats (3,0x103),(4,0x104),(5,0x105) with dout_last on beat 3. done at T+7.
- Wrap: first=30, last=1 → idx sequence 30,31,0,1 with data 0x11E,0x11F,0x000(r0),0x101.
- Backpressure: first=last=7, dout_ready low for 5 cycles after valid → dout_data=0x107 held stable 6 cycles. Single beat with dout_last=1. done 1 cycle after the handshake.
- start pulsed again while busy, and during DONE → ignored; beat count unchanged.
- rst driven low during the second SEND of a 4-register dump → all outputs 0 immediately, no done. A fresh start after release restarts from first.
- REG_DUMP_CHKSUM_EN, first=3, last=5 → fourth beat dout_data=0x103^0x104^0x105=0x102, idx=0, last=1.
